// File: rtl/axi_arb_pkg.sv
// Shared types and AXI constants for the HP-port read arbiter.
// Holds the arbiter FSM states and the AxSIZE encoding helper.
package axi_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } arb_state_e;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

   // AxSIZE code for a power-of-two beat width in bytes (1..128).
   function automatic logic [2:0] size_from_bytes(input int unsigned nbytes);
      logic [2:0] s;
      s = 3'd0;
      for (int i = 1; i < 8; i++) begin
         if (nbytes == (32'd1 << i)) s = 3'(i);
      end
      return s;
   endfunction

endpackage

// File: rtl/axi_hp_read_arbiter_rr_pick.sv
// Round-robin picker: first asserted request at or after ptr_i, modulo NUM_REQ.
// Purely combinational, zero latency; no flow control of its own.
module rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int PTR_W   = 2
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [PTR_W-1:0]   ptr_i,
   output logic               any_o,
   output logic [PTR_W-1:0]   idx_o
);

   always_comb begin
      logic [PTR_W-1:0] cand;
      cand  = '0;
      any_o = 1'b0;
      idx_o = '0;
      // Walk from the farthest candidate back to ptr_i so the nearest match wins.
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         cand = PTR_W'((int'(ptr_i) + k) % NUM_REQ);
         if (req_i[cand]) begin
            any_o = 1'b1;
            idx_o = cand;
         end
      end
   end

endmodule

// File: rtl/axi_hp_read_arbiter.sv
// Round-robin sharing of one AXI read channel: AR issued 1 cycle after a request is seen in IDLE,
// R beats steered to the granted requester with zero latency; rd_ready backpressure drives RREADY directly.
module axi_hp_read_arbiter
   import axi_arb_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int ID_WIDTH   = 2,
   parameter int DATA_WIDTH = 128,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                          S_AXI_ACLK,
   input  logic                          S_AXI_ARESETN,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_REQ*8-1:0]          req_len,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic [NUM_REQ-1:0]            rd_valid,
   output logic [DATA_WIDTH-1:0]         rd_data,
   output logic                          rd_last,
   input  logic [NUM_REQ-1:0]            rd_ready,
   output logic [ID_WIDTH-1:0]           M_AXI_ARID,
   output logic [ADDR_WIDTH-1:0]         M_AXI_ARADDR,
   output logic [7:0]                    M_AXI_ARLEN,
   output logic [2:0]                    M_AXI_ARSIZE,
   output logic [1:0]                    M_AXI_ARBURST,
   output logic                          M_AXI_ARVALID,
   output logic                          M_AXI_ARLOCK,
   output logic [3:0]                    M_AXI_ARCACHE,
   output logic [2:0]                    M_AXI_ARPROT,
   output logic [3:0]                    M_AXI_ARQOS,
   input  logic                          M_AXI_ARREADY,
   input  logic [ID_WIDTH-1:0]           M_AXI_RID,
   input  logic [DATA_WIDTH-1:0]         M_AXI_RDATA,
   input  logic [1:0]                    M_AXI_RRESP,
   input  logic                          M_AXI_RLAST,
   input  logic                          M_AXI_RVALID,
   output logic                          M_AXI_RREADY,
   output logic                          prot_err
);

   localparam int PTR_W = $clog2(NUM_REQ);
   localparam logic [2:0] AR_SIZE = size_from_bytes(DATA_WIDTH / 8);

   arb_state_e            state_q;
   logic [PTR_W-1:0]      g_q;
   logic [PTR_W-1:0]      rr_ptr_q;
   logic [PTR_W-1:0]      rr_ptr_d;
   logic [ADDR_WIDTH-1:0] araddr_q;
   logic [7:0]            arlen_q;
   logic [7:0]            cnt_q;
   logic                  arvalid_q;
   logic                  prot_err_q;
   logic                  prot_err_d;

   logic                  pick_any;
   logic [PTR_W-1:0]      pick_idx;
   logic                  in_data;
   logic                  ar_hs;
   logic                  r_hs;
   logic                  last_exp;

   logic [ADDR_WIDTH-1:0] addr_a [NUM_REQ];
   logic [7:0]            len_a  [NUM_REQ];

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign addr_a[i] = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      assign len_a[i]  = req_len[i*8 +: 8];
   end

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_pick (
      .req_i (req_valid),
      .ptr_i (rr_ptr_q),
      .any_o (pick_any),
      .idx_o (pick_idx)
   );

   assign in_data  = (state_q == DATA);
   assign ar_hs    = arvalid_q & M_AXI_ARREADY;
   assign r_hs     = M_AXI_RVALID & M_AXI_RREADY;
   assign last_exp = (cnt_q == arlen_q);
   assign rr_ptr_d = (g_q == PTR_W'(NUM_REQ - 1)) ? '0 : g_q + PTR_W'(1);

   // R channel is a straight pass-through; RREADY is gated off outside DATA so stray beats stall.
   assign M_AXI_RREADY = in_data & rd_ready[g_q];
   assign rd_valid     = (in_data & M_AXI_RVALID) ? (NUM_REQ'(1) << g_q) : '0;
   assign rd_data      = M_AXI_RDATA;
   assign rd_last      = in_data & M_AXI_RLAST;
   assign req_ready    = ar_hs ? (NUM_REQ'(1) << g_q) : '0;

   assign prot_err_d = prot_err_q |
                       (r_hs & ((M_AXI_RID != ID_WIDTH'(g_q)) |
                                (M_AXI_RRESP != AXI_RESP_OKAY) |
                                (M_AXI_RLAST != last_exp)));

   assign M_AXI_ARID    = ID_WIDTH'(g_q);
   assign M_AXI_ARADDR  = araddr_q;
   assign M_AXI_ARLEN   = arlen_q;
   assign M_AXI_ARSIZE  = AR_SIZE;
   assign M_AXI_ARBURST = AXI_BURST_INCR;
   assign M_AXI_ARVALID = arvalid_q;
   assign M_AXI_ARLOCK  = 1'b0;
   assign M_AXI_ARCACHE = 4'd0;
   assign M_AXI_ARPROT  = 3'd0;
   assign M_AXI_ARQOS   = 4'd0;
   assign prot_err      = prot_err_q;

   always_ff @(posedge S_AXI_ACLK) begin
      if (!S_AXI_ARESETN) begin
         state_q    <= IDLE;
         g_q        <= '0;
         rr_ptr_q   <= '0;
         araddr_q   <= '0;
         arlen_q    <= '0;
         arvalid_q  <= 1'b0;
         cnt_q      <= '0;
         prot_err_q <= 1'b0;
      end else begin
         prot_err_q <= prot_err_d;
         case (state_q)
            IDLE: begin
               if (pick_any) begin
                  g_q       <= pick_idx;
                  araddr_q  <= addr_a[pick_idx];
                  arlen_q   <= len_a[pick_idx];
                  arvalid_q <= 1'b1;
                  state_q   <= ADDR;
               end
            end
            ADDR: begin
               if (M_AXI_ARREADY) begin
                  arvalid_q <= 1'b0;
                  cnt_q     <= '0;
                  state_q   <= DATA;
               end
            end
            DATA: begin
               if (r_hs) begin
                  cnt_q <= cnt_q + 8'd1;
                  if (M_AXI_RLAST) begin
                     rr_ptr_q <= rr_ptr_d;
                     state_q  <= IDLE;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_hp_read_arbiter.sv
// Directed bench for axi_hp_read_arbiter against a small DDR read-slave model.
// Slave raises ARREADY one cycle after ARVALID and returns ddr_word(addr, beat) per beat.
module tb_axi_hp_read_arbiter;

   logic         clk = 1'b0;
   logic         aresetn = 1'b0;
   logic [3:0]   req_valid = '0;
   logic [127:0] req_addr = '0;
   logic [31:0]  req_len = '0;
   logic [3:0]   req_ready;
   logic [3:0]   rd_valid;
   logic [127:0] rd_data;
   logic         rd_last;
   logic [3:0]   rd_ready = 4'hF;
   logic [1:0]   M_AXI_ARID;
   logic [31:0]  M_AXI_ARADDR;
   logic [7:0]   M_AXI_ARLEN;
   logic [2:0]   M_AXI_ARSIZE;
   logic [1:0]   M_AXI_ARBURST;
   logic         M_AXI_ARVALID;
   logic         M_AXI_ARLOCK;
   logic [3:0]   M_AXI_ARCACHE;
   logic [2:0]   M_AXI_ARPROT;
   logic [3:0]   M_AXI_ARQOS;
   logic         M_AXI_ARREADY;
   logic [1:0]   M_AXI_RID;
   logic [127:0] M_AXI_RDATA;
   logic [1:0]   M_AXI_RRESP;
   logic         M_AXI_RLAST;
   logic         M_AXI_RVALID;
   logic         M_AXI_RREADY;
   logic         prot_err;

   always #5 clk = ~clk;

   axi_hp_read_arbiter dut (
      .S_AXI_ACLK    (clk),
      .S_AXI_ARESETN (aresetn),
      .req_valid     (req_valid),
      .req_addr      (req_addr),
      .req_len       (req_len),
      .req_ready     (req_ready),
      .rd_valid      (rd_valid),
      .rd_data       (rd_data),
      .rd_last       (rd_last),
      .rd_ready      (rd_ready),
      .M_AXI_ARID    (M_AXI_ARID),
      .M_AXI_ARADDR  (M_AXI_ARADDR),
      .M_AXI_ARLEN   (M_AXI_ARLEN),
      .M_AXI_ARSIZE  (M_AXI_ARSIZE),
      .M_AXI_ARBURST (M_AXI_ARBURST),
      .M_AXI_ARVALID (M_AXI_ARVALID),
      .M_AXI_ARLOCK  (M_AXI_ARLOCK),
      .M_AXI_ARCACHE (M_AXI_ARCACHE),
      .M_AXI_ARPROT  (M_AXI_ARPROT),
      .M_AXI_ARQOS   (M_AXI_ARQOS),
      .M_AXI_ARREADY (M_AXI_ARREADY),
      .M_AXI_RID     (M_AXI_RID),
      .M_AXI_RDATA   (M_AXI_RDATA),
      .M_AXI_RRESP   (M_AXI_RRESP),
      .M_AXI_RLAST   (M_AXI_RLAST),
      .M_AXI_RVALID  (M_AXI_RVALID),
      .M_AXI_RREADY  (M_AXI_RREADY),
      .prot_err      (prot_err)
   );

   function automatic logic [127:0] ddr_word(input logic [31:0] a, input logic [7:0] b);
      logic [31:0] w;
      w = a + {20'd0, b, 4'd0};
      return {w, ~w, w ^ 32'hA5A5_5A5A, 24'd0, b};
   endfunction

   // DDR read-slave model
   logic       s_arready = 1'b0;
   logic       s_rvalid = 1'b0;
   logic [31:0] s_addr = '0;
   logic [7:0] s_len = '0;
   logic [1:0] s_id = '0;
   logic [7:0] s_beat = '0;
   int         early_last = -1;

   always @(posedge clk) begin
      if (!aresetn) begin
         s_arready <= 1'b0;
         s_rvalid  <= 1'b0;
         s_beat    <= '0;
      end else begin
         if (M_AXI_ARVALID && s_arready) begin
            s_arready <= 1'b0;
            s_addr    <= M_AXI_ARADDR;
            s_len     <= M_AXI_ARLEN;
            s_id      <= M_AXI_ARID;
            s_beat    <= '0;
            s_rvalid  <= 1'b1;
         end else if (M_AXI_ARVALID) begin
            s_arready <= 1'b1;
         end
         if (s_rvalid && M_AXI_RREADY) begin
            s_beat <= s_beat + 8'd1;
            if (M_AXI_RLAST) s_rvalid <= 1'b0;
         end
      end
   end

   assign M_AXI_ARREADY = s_arready;
   assign M_AXI_RVALID  = s_rvalid;
   assign M_AXI_RID     = s_id;
   assign M_AXI_RRESP   = 2'b00;
   assign M_AXI_RDATA   = ddr_word(s_addr, s_beat);
   assign M_AXI_RLAST   = (early_last >= 0) ? (int'(s_beat) == early_last) : (s_beat == s_len);

   // Monitors: delivered beats, AR handshakes, rd_valid one-hot violations
   typedef struct {int who; logic [127:0] d; logic last; int cyc;} beat_t;
   typedef struct {int id; logic [31:0] a; int len; int cyc;} ar_t;
   beat_t beats[$];
   ar_t   ars[$];
   int    cyc = 0;
   int    multi_hot = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (aresetn) begin
         for (int i = 0; i < 4; i++)
            if (rd_valid[i] && rd_ready[i]) beats.push_back('{i, rd_data, rd_last, cyc});
         if (M_AXI_ARVALID && M_AXI_ARREADY)
            ars.push_back('{int'(M_AXI_ARID), M_AXI_ARADDR, int'(M_AXI_ARLEN), cyc});
         if ($countones(rd_valid) > 1) multi_hot <= multi_hot + 1;
      end
   end

   int n_vec = 0;
   int n_mis = 0;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_beats(input int want, input string tag);
      for (int n = 0; n < 200 && beats.size() < want; n++) tick();
      chk(tag, beats.size(), want);
   endtask

   task automatic issue(input int idx, input logic [31:0] a, input logic [7:0] l);
      logic ok;
      ok = 1'b0;
      req_addr[idx*32 +: 32] = a;
      req_len[idx*8 +: 8]    = l;
      req_valid[idx]         = 1'b1;
      for (int n = 0; n < 50 && !ok; n++) begin
         tick();
         ok = req_ready[idx];
      end
      tick();
      req_valid[idx] = 1'b0;
      chk("issue req_ready seen", ok, 1'b1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0;
      int exp_g[5];
      exp_g = '{0, 1, 2, 3, 0};

      // Reset state
      repeat (3) tick();
      chk("rst arvalid", M_AXI_ARVALID, 0);
      chk("rst araddr", M_AXI_ARADDR, 0);
      chk("rst arlen", M_AXI_ARLEN, 0);
      chk("rst arid", M_AXI_ARID, 0);
      chk("rst rready", M_AXI_RREADY, 0);
      chk("rst req_ready", req_ready, 0);
      chk("rst rd_valid", rd_valid, 0);
      chk("rst prot_err", prot_err, 0);
      chk("arsize", M_AXI_ARSIZE, 3'd4);
      chk("arburst", M_AXI_ARBURST, 2'b01);
      chk("ar tieoffs", {M_AXI_ARLOCK, M_AXI_ARCACHE, M_AXI_ARPROT, M_AXI_ARQOS}, 0);
      aresetn = 1'b1;
      tick();

      // All requesters valid, len 0: rotation 0,1,2,3,0 with 2-cycle turnaround
      for (int i = 0; i < 4; i++) begin
         req_addr[i*32 +: 32] = 32'h1000 * i;
         req_len[i*8 +: 8]    = 8'd0;
      end
      req_valid = 4'hF;
      for (int n = 0; n < 100 && ars.size() < 5; n++) tick();
      req_valid = 4'h0;
      wait_beats(5, "rot beats count");
      chk("rot ar count", ars.size(), 5);
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("rot arid %0d", k), ars[k].id, exp_g[k]);
         chk($sformatf("rot araddr %0d", k), ars[k].a, 32'h1000 * exp_g[k]);
         chk($sformatf("rot beat who %0d", k), beats[k].who, exp_g[k]);
         chk($sformatf("rot beat last %0d", k), beats[k].last, 1'b1);
         chk($sformatf("rot beat cyc %0d", k), beats[k].cyc, ars[k].cyc + 1);
      end
      for (int k = 1; k < 5; k++)
         chk($sformatf("rot turnaround %0d", k), ars[k].cyc, beats[k-1].cyc + 3);
      chk("rot prot_err", prot_err, 0);

      // Single request, requester 1, addr 0x100, len 3
      repeat (3) tick();
      beats.delete();
      ars.delete();
      c0 = cyc;
      req_addr[32 +: 32] = 32'h100;
      req_len[8 +: 8]    = 8'd3;
      req_valid[1]       = 1'b1;
      chk("t1 arvalid c0", M_AXI_ARVALID, 0);
      tick();
      chk("t1 arvalid c1", M_AXI_ARVALID, 1);
      chk("t1 arid", M_AXI_ARID, 2'd1);
      chk("t1 arlen", M_AXI_ARLEN, 8'd3);
      chk("t1 araddr", M_AXI_ARADDR, 32'h100);
      chk("t1 req_ready c1", req_ready, 4'b0000);
      tick();
      chk("t1 req_ready c2", req_ready, 4'b0010);
      chk("t1 arvalid c2", M_AXI_ARVALID, 1);
      tick();
      req_valid[1] = 1'b0;
      chk("t1 req_ready c3", req_ready, 4'b0000);
      chk("t1 arvalid c3", M_AXI_ARVALID, 0);
      wait_beats(4, "t1 beat count");
      chk("t1 ar cycle", ars[0].cyc, c0 + 2);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("t1 who %0d", k), beats[k].who, 1);
         chk($sformatf("t1 data %0d", k), beats[k].d, ddr_word(32'h100, 8'(k)));
         chk($sformatf("t1 last %0d", k), beats[k].last, k == 3);
      end
      chk("t1 prot_err", prot_err, 0);

      // rd_ready backpressure for 5 cycles mid-burst
      repeat (2) tick();
      beats.delete();
      issue(2, 32'h200, 8'd7);
      for (int n = 0; n < 50 && beats.size() < 2; n++) tick();
      rd_ready[2] = 1'b0;
      #1;
      for (int j = 0; j < 5; j++) begin
         chk($sformatf("bp rready low %0d", j), M_AXI_RREADY, 0);
         chk($sformatf("bp rd_valid %0d", j), rd_valid, 4'b0100);
         tick();
      end
      chk("bp beats held", beats.size(), 2);
      rd_ready[2] = 1'b1;
      #1;
      chk("bp rready high", M_AXI_RREADY, 1);
      wait_beats(8, "bp beat count");
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("bp who %0d", k), beats[k].who, 2);
         chk($sformatf("bp data %0d", k), beats[k].d, ddr_word(32'h200, 8'(k)));
         chk($sformatf("bp last %0d", k), beats[k].last, k == 7);
      end
      chk("bp prot_err", prot_err, 0);

      // Early RLAST on beat 2 of len 3
      repeat (2) tick();
      beats.delete();
      early_last = 1;
      issue(3, 32'h300, 8'd3);
      for (int n = 0; n < 50 && beats.size() < 1; n++) tick();
      chk("early prot_err before", prot_err, 0);
      wait_beats(2, "early beat count");
      chk("early prot_err after", prot_err, 1);
      chk("early rd_last", beats[1].last, 1);
      repeat (4) tick();
      early_last = -1;
      chk("early prot_err sticky", prot_err, 1);
      issue(1, 32'h400, 8'd0);
      wait_beats(3, "post-err beat count");
      chk("post-err data", beats[2].d, ddr_word(32'h400, 8'd0));
      chk("post-err prot_err", prot_err, 1);

      // Reset during DATA; rr_ptr must return to 0
      repeat (2) tick();
      rd_ready[2] = 1'b0;
      issue(2, 32'h500, 8'd7);
      tick();
      chk("rstd in data rd_valid", rd_valid, 4'b0100);
      aresetn = 1'b0;
      tick();
      chk("rstd rd_valid", rd_valid, 0);
      chk("rstd rready", M_AXI_RREADY, 0);
      chk("rstd arvalid", M_AXI_ARVALID, 0);
      chk("rstd prot_err", prot_err, 0);
      chk("rstd req_ready", req_ready, 0);
      rd_ready  = 4'hF;
      aresetn   = 1'b1;
      beats.delete();
      ars.delete();
      req_addr[32 +: 32] = 32'h600;
      req_len[8 +: 8]    = 8'd0;
      req_addr[96 +: 32] = 32'h700;
      req_len[24 +: 8]   = 8'd0;
      req_valid = 4'b1010;
      for (int n = 0; n < 20 && req_ready == 4'b0000; n++) tick();
      chk("rstd pick after reset", req_ready, 4'b0010);
      tick();
      req_valid = 4'b0000;
      wait_beats(1, "rstd beat count");
      chk("rstd beat who", beats[0].who, 1);
      chk("rstd beat data", beats[0].d, ddr_word(32'h600, 8'd0));
      chk("rd_valid one-hot", multi_hot, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule

// File: doc/axi_hp_read_arbiter.md
# axi_hp_read_arbiter

Round-robin read arbiter that lets NUM_REQ internal read requesters (weight/activation fetch DMAs) share the single AXI HP read channel to DDR. It issues one full AR burst at a time on behalf of the granted requester and steers the returning R beats back to that requester. The write channels are not handled here. It sits between the accelerator's fetch engines and the HP port, which is the DDR slave model in simulation.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ID_WIDTH, 2, AXI ID width; must be ≥ clog2(NUM_REQ)
- DATA_WIDTH, 128, AXI data width in bits
- ADDR_WIDTH, 32, AXI address width

Ports:
- S_AXI_ACLK  in  1  single clock
- S_AXI_ARESETN  in  1  reset; one clock; reset is synchronous and active-low
- req_valid  in  NUM_REQ  per-requester burst request
- req_addr  in  NUM_REQ*ADDR_WIDTH  byte address, packed, requester i at slice i
- req_len  in  NUM_REQ*8  AXI length (beats-1), packed
- req_ready  out  NUM_REQ  one-cycle pulse: request accepted (AR handshake done)
- rd_valid  out  NUM_REQ  beat valid, only the granted bit can be high
- rd_data  out  DATA_WIDTH  read data, broadcast to all requesters
- rd_last  out  1  last beat of burst
- rd_ready  in  NUM_REQ  per-requester beat accept
- M_AXI_ARID / ARADDR / ARLEN / ARSIZE / ARBURST / ARVALID  out  ID_WIDTH / ADDR_WIDTH / 8 / 3 / 2 / 1  AR channel
- M_AXI_ARLOCK, ARCACHE, ARPROT, ARQOS  out  1/4/3/4  tied to 0
- M_AXI_ARREADY  in  1
- M_AXI_RID / RDATA / RRESP / RLAST / RVALID  in  ID_WIDTH / DATA_WIDTH / 2 / 1 / 1
- M_AXI_RREADY  out  1
- prot_err  out  1  sticky protocol error flag

## Operation
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - If any req_valid is high, pick the first requester at or after rr_ptr (modulo NUM_REQ).
  - Register grant index g, ARADDR, ARLEN and ARID=g; set ARVALID; go to ADDR.
- ADDR:
  - Hold ARVALID and all AR fields stable until ARREADY.
  - On handshake: req_ready[g]=1 in that same cycle (combinational), ARVALID drops next cycle, beat counter cleared, go to DATA.
  - A requester must hold req_valid/addr/len stable until its req_ready.
- DATA: combinational pass-through.
  - rd_valid[g]=M_AXI_RVALID; M_AXI_RREADY=rd_ready[g]; rd_last=M_AXI_RLAST.
  - Beat counter increments on each R handshake.
  - On the RLAST handshake: rr_ptr ← (g+1) mod NUM_REQ, go to IDLE.
- Fixed AR fields: ARSIZE=clog2(DATA_WIDTH/8), ARBURST=INCR (2'b01).
- prot_err sets, and stays set until reset, on an R handshake with any of:
  - RID≠g
  - RRESP≠OKAY
  - RLAST high while count≠len
  - RLAST low while count==len
- Outside DATA: M_AXI_RREADY=0 and rd_valid=0, so stray RVALID is never accepted.

## Timing
- Reset values: ARVALID=0, ARADDR/ARLEN/ARID=0, RREADY=0, req_ready=0, rd_valid=0, prot_err=0, rr_ptr=0, state IDLE.
- Reset mid-burst aborts it immediately. The DDR side must be reset together with the arbiter.
- Acceptance latency: req_valid seen in IDLE at cycle 0 → ARVALID high at cycle 1. Against a slave that raises ARREADY one cycle after ARVALID, the handshake and req_ready land at cycle 2.
- R path adds zero latency; backpressure from rd_ready passes straight to RREADY.
- Burst turnaround: RLAST handshake at cycle t → IDLE at t+1 (arbitration) → next ARVALID at t+2.
- A requester that deasserts req_valid in IDLE is simply not picked. Deasserting it in ADDR is illegal and the arbiter ignores it.
- Simultaneous requests: the winner is the first valid requester at or after rr_ptr. A requester that was just served has lowest priority next time.
- len=0 bursts: DATA lasts exactly one R handshake.

## Structure
- Package axi_arb_pkg holds:
  - state enum {IDLE, ADDR, DATA}
  - AXI_BURST_INCR, AXI_RESP_OKAY
  - a size_from_bytes function
- Sub-module rr_pick: combinational round-robin picker with inputs req[NUM_REQ] and ptr, outputs any and idx.

## Test plan
- Single request, requester 1, addr 0x100, len 3 → ARID=1, ARLEN=3, req_ready[1] at cycle 2, four beats on rd_valid[1] only, rd_last on beat 4, prot_err=0.
- All four requesters valid continuously, len 0 each → grants in order 0,1,2,3,0; each new ARVALID 2 cycles after the previous RLAST.
- rd_ready[g] low for 5 cycles mid-burst → RREADY low for the same 5 cycles, no beat lost or duplicated, data matches DDR contents.
- DDR model returns RLAST early (beat 2 of len 3) → prot_err rises the cycle after that handshake and stays high.
- Synchronous reset asserted during DATA → next cycle: state IDLE, rd_valid=0, RREADY=0, rr_ptr=0.
